// File: rtl/l15_transducer_bridge.sv
// Bridge between the core transducer port and the L1.5 cache.
// A 2-entry request FIFO decouples the core from L1.5 header acceptance, an
// outstanding counter throttles issue, and a 1-entry register holds responses
// until the core consumes them. Interrupt-type returns are acked and dropped.
module l15_transducer_bridge #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [3:0]  INT_RET_TYPE    = 4'd7,
   parameter int unsigned ADDR_W_CORE     = 32
) (
   input  logic                   clk,
   input  logic                   nrst,
   // core request side
   input  logic [4:0]             core_rqtype,
   input  logic [2:0]             core_size,
   input  logic [ADDR_W_CORE-1:0] core_address,
   input  logic [63:0]            core_data,
   input  logic                   core_val,
   output logic                   core_header_ack,
   // core response side
   output logic                   core_resp_val,
   output logic [63:0]            core_resp_data_0,
   output logic [63:0]            core_resp_data_1,
   output logic [3:0]             core_resp_returntype,
   input  logic                   core_resp_ack,
   // L1.5 request side
   output logic [4:0]             transducer_l15_rqtype,
   output logic [2:0]             transducer_l15_size,
   output logic [39:0]            transducer_l15_address,
   output logic [63:0]            transducer_l15_data,
   output logic                   transducer_l15_val,
   input  logic                   l15_transducer_header_ack,
   // L1.5 response side
   input  logic                   l15_transducer_val,
   input  logic [63:0]            l15_transducer_data_0,
   input  logic [63:0]            l15_transducer_data_1,
   input  logic [3:0]             l15_transducer_returntype,
   output logic                   transducer_l15_req_ack
);

   localparam logic [1:0] MaxOut = 2'(MAX_OUTSTANDING);

   typedef struct packed {
      logic [4:0]             rqtype;
      logic [2:0]             size;
      logic [ADDR_W_CORE-1:0] address;
      logic [63:0]            data;
   } req_t;

   req_t        fifo_q [2];
   req_t        fifo_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic [1:0]  outstanding_q, outstanding_d;

   logic        resp_val_q, resp_val_d;
   logic [63:0] resp_data_0_q, resp_data_0_d;
   logic [63:0] resp_data_1_q, resp_data_1_d;
   logic [3:0]  resp_type_q, resp_type_d;

   logic        push;
   logic        pop;
   logic        rsp_cap;
   req_t        head;

   // Handshakes; combinational acks are forced low while reset is asserted.
   always_comb begin
      head                   = fifo_q[rd_ptr_q];
      core_header_ack        = ~nrst & core_val & (count_q != 2'd2);
      transducer_l15_val     = (count_q != 2'd0) & (outstanding_q < MaxOut);
      transducer_l15_req_ack = ~nrst & l15_transducer_val & ~resp_val_q;
      push                   = core_header_ack;
      pop                    = transducer_l15_val & l15_transducer_header_ack;
      rsp_cap                = transducer_l15_req_ack &
                               (l15_transducer_returntype != INT_RET_TYPE);
   end

   // L1.5 payload comes straight from the FIFO head; the head only moves on pop.
   always_comb begin
      transducer_l15_rqtype  = head.rqtype;
      transducer_l15_size    = head.size;
      transducer_l15_address = 40'(head.address);
      transducer_l15_data    = head.data;
      core_resp_val          = resp_val_q;
      core_resp_data_0       = resp_data_0_q;
      core_resp_data_1       = resp_data_1_q;
      core_resp_returntype   = resp_type_q;
   end

   // Request FIFO next state: push at tail, pop at head, count tracks occupancy.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q].rqtype  = core_rqtype;
         fifo_d[wr_ptr_q].size    = core_size;
         fifo_d[wr_ptr_q].address = core_address;
         fifo_d[wr_ptr_q].data    = core_data;
         wr_ptr_d                 = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Outstanding counter: issue increments, a forwarded response decrements.
   always_comb begin
      outstanding_d = outstanding_q;
      if (pop && !rsp_cap) begin
         outstanding_d = outstanding_q + 2'd1;
      end else if (rsp_cap && !pop && (outstanding_q != 2'd0)) begin
         outstanding_d = outstanding_q - 2'd1;
      end
   end

   // Response register: capture when empty, release on core ack.
   always_comb begin
      resp_val_d    = resp_val_q;
      resp_data_0_d = resp_data_0_q;
      resp_data_1_d = resp_data_1_q;
      resp_type_d   = resp_type_q;
      if (resp_val_q && core_resp_ack) begin
         resp_val_d = 1'b0;
      end else if (rsp_cap) begin
         resp_val_d    = 1'b1;
         resp_data_0_d = l15_transducer_data_0;
         resp_data_1_d = l15_transducer_data_1;
         resp_type_d   = l15_transducer_returntype;
      end
   end

   // State registers; reset discards queued requests and any held response.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         fifo_q[0]     <= '0;
         fifo_q[1]     <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         outstanding_q <= 2'd0;
         resp_val_q    <= 1'b0;
         resp_data_0_q <= '0;
         resp_data_1_q <= '0;
         resp_type_q   <= '0;
      end else begin
         fifo_q        <= fifo_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         resp_val_q    <= resp_val_d;
         resp_data_0_q <= resp_data_0_d;
         resp_data_1_q <= resp_data_1_d;
         resp_type_q   <= resp_type_d;
      end
   end

   // A response with nothing outstanding means L1.5 answered a request never issued.
   a_no_underflow: assert property (@(posedge clk) disable iff (nrst)
      !(rsp_cap && !pop && (outstanding_q == 2'd0)));

endmodule

// File: tb/tb_l15_transducer_bridge.sv
// Directed bench with request and response scoreboards for l15_transducer_bridge.
module tb_l15_transducer_bridge;

   logic        clk;
   logic        nrst;
   logic [4:0]  core_rqtype;
   logic [2:0]  core_size;
   logic [31:0] core_address;
   logic [63:0] core_data;
   logic        core_val;
   logic        core_header_ack;
   logic        core_resp_val;
   logic [63:0] core_resp_data_0;
   logic [63:0] core_resp_data_1;
   logic [3:0]  core_resp_returntype;
   logic        core_resp_ack;
   logic [4:0]  transducer_l15_rqtype;
   logic [2:0]  transducer_l15_size;
   logic [39:0] transducer_l15_address;
   logic [63:0] transducer_l15_data;
   logic        transducer_l15_val;
   logic        l15_transducer_header_ack;
   logic        l15_transducer_val;
   logic [63:0] l15_transducer_data_0;
   logic [63:0] l15_transducer_data_1;
   logic [3:0]  l15_transducer_returntype;
   logic        transducer_l15_req_ack;

   typedef struct {
      logic [4:0]  rqtype;
      logic [2:0]  size;
      logic [31:0] address;
      logic [63:0] data;
   } req_t;

   typedef struct {
      logic [63:0] d0;
      logic [63:0] d1;
      logic [3:0]  rt;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   checks = 0;
   int   errors = 0;

   l15_transducer_bridge #(
      .MAX_OUTSTANDING(2),
      .INT_RET_TYPE   (4'd7),
      .ADDR_W_CORE    (32)
   ) dut (
      .clk                      (clk),
      .nrst                     (nrst),
      .core_rqtype              (core_rqtype),
      .core_size                (core_size),
      .core_address             (core_address),
      .core_data                (core_data),
      .core_val                 (core_val),
      .core_header_ack          (core_header_ack),
      .core_resp_val            (core_resp_val),
      .core_resp_data_0         (core_resp_data_0),
      .core_resp_data_1         (core_resp_data_1),
      .core_resp_returntype     (core_resp_returntype),
      .core_resp_ack            (core_resp_ack),
      .transducer_l15_rqtype    (transducer_l15_rqtype),
      .transducer_l15_size      (transducer_l15_size),
      .transducer_l15_address   (transducer_l15_address),
      .transducer_l15_data      (transducer_l15_data),
      .transducer_l15_val       (transducer_l15_val),
      .l15_transducer_header_ack(l15_transducer_header_ack),
      .l15_transducer_val       (l15_transducer_val),
      .l15_transducer_data_0    (l15_transducer_data_0),
      .l15_transducer_data_1    (l15_transducer_data_1),
      .l15_transducer_returntype(l15_transducer_returntype),
      .transducer_l15_req_ack   (transducer_l15_req_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [4:0] rq, input logic [2:0] sz, input logic [31:0] a,
                          input logic [63:0] d);
      core_rqtype  = rq;
      core_size    = sz;
      core_address = a;
      core_data    = d;
      core_val     = 1'b1;
   endtask

   task automatic set_rsp(input logic [63:0] d0, input logic [63:0] d1, input logic [3:0] rt);
      l15_transducer_data_0     = d0;
      l15_transducer_data_1     = d1;
      l15_transducer_returntype = rt;
      l15_transducer_val        = 1'b1;
   endtask

   // Scoreboard monitor, sampled mid-cycle between input changes and the next edge.
   always @(negedge clk) begin
      if (core_val && core_header_ack) begin
         req_q.push_back('{core_rqtype, core_size, core_address, core_data});
      end
      if (l15_transducer_val && transducer_l15_req_ack && l15_transducer_returntype != 4'd7) begin
         rsp_q.push_back('{l15_transducer_data_0, l15_transducer_data_1,
                           l15_transducer_returntype});
      end
      if (transducer_l15_val && l15_transducer_header_ack) begin
         if (req_q.size() == 0) begin
            check_eq("req_unexpected", 64'd1, 64'd0);
         end else begin
            req_t e;
            e = req_q.pop_front();
            check_eq("sb_rqtype", {59'd0, transducer_l15_rqtype}, {59'd0, e.rqtype});
            check_eq("sb_size", {61'd0, transducer_l15_size}, {61'd0, e.size});
            check_eq("sb_addr", {24'd0, transducer_l15_address}, {32'd0, e.address});
            check_eq("sb_data", transducer_l15_data, e.data);
         end
      end
      if (core_resp_val && core_resp_ack) begin
         if (rsp_q.size() == 0) begin
            check_eq("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            check_eq("sb_rsp_d0", core_resp_data_0, r.d0);
            check_eq("sb_rsp_d1", core_resp_data_1, r.d1);
            check_eq("sb_rsp_rt", {60'd0, core_resp_returntype}, {60'd0, r.rt});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nrst = 1'b1;
      core_rqtype = '0; core_size = '0; core_address = '0; core_data = '0;
      core_val = 1'b1; core_resp_ack = 1'b0;
      l15_transducer_header_ack = 1'b0;
      set_rsp(64'h1, 64'h2, 4'd0);
      #12;
      check_eq("rst_hdr_ack", {63'd0, core_header_ack}, 64'd0);
      check_eq("rst_req_ack", {63'd0, transducer_l15_req_ack}, 64'd0);
      check_eq("rst_l15_val", {63'd0, transducer_l15_val}, 64'd0);
      check_eq("rst_resp_val", {63'd0, core_resp_val}, 64'd0);
      check_eq("rst_l15_addr", {24'd0, transducer_l15_address}, 64'd0);
      tick();
      nrst = 1'b0; core_val = 1'b0; l15_transducer_val = 1'b0;

      // 1: single load
      tick();
      set_req(5'd0, 3'd3, 32'h8000_0040, 64'h0);
      #1;
      check_eq("t1_hdr_ack", {63'd0, core_header_ack}, 64'd1);
      check_eq("t1_no_bypass", {63'd0, transducer_l15_val}, 64'd0);
      tick();
      core_val = 1'b0;
      #1;
      check_eq("t1_l15_val", {63'd0, transducer_l15_val}, 64'd1);
      check_eq("t1_addr", {24'd0, transducer_l15_address}, 64'h00_8000_0040);
      l15_transducer_header_ack = 1'b1;
      tick();
      l15_transducer_header_ack = 1'b0;
      #1;
      check_eq("t1_fifo_empty", {63'd0, transducer_l15_val}, 64'd0);
      set_rsp(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 4'd0);
      #1;
      check_eq("t1_req_ack", {63'd0, transducer_l15_req_ack}, 64'd1);
      check_eq("t1_resp_early", {63'd0, core_resp_val}, 64'd0);
      tick();
      l15_transducer_val = 1'b0;
      #1;
      check_eq("t1_resp_val", {63'd0, core_resp_val}, 64'd1);
      check_eq("t1_resp_d0", core_resp_data_0, 64'hDEAD_BEEF_0000_0001);
      tick();
      tick();
      check_eq("t1_resp_held", {63'd0, core_resp_val}, 64'd1);
      check_eq("t1_resp_held_d0", core_resp_data_0, 64'hDEAD_BEEF_0000_0001);
      core_resp_ack = 1'b1;
      tick();
      core_resp_ack = 1'b0;
      #1;
      check_eq("t1_resp_done", {63'd0, core_resp_val}, 64'd0);

      // 2: back-to-back accepts with L1.5 stalled
      tick();
      set_req(5'd1, 3'd2, 32'h0000_1000, 64'hAAAA_0000_0000_0001);
      #1;
      check_eq("t2_acc_a", {63'd0, core_header_ack}, 64'd1);
      tick();
      set_req(5'd2, 3'd3, 32'h0000_2008, 64'hBBBB_0000_0000_0002);
      #1;
      check_eq("t2_acc_b", {63'd0, core_header_ack}, 64'd1);
      tick();
      set_req(5'd3, 3'd1, 32'hFFFF_FFF0, 64'hCCCC_0000_0000_0003);
      #1;
      check_eq("t2_full", {63'd0, core_header_ack}, 64'd0);
      tick();
      check_eq("t2_stall", {63'd0, core_header_ack}, 64'd0);
      check_eq("t2_l15_val", {63'd0, transducer_l15_val}, 64'd1);
      l15_transducer_header_ack = 1'b1;
      #1;
      check_eq("t2_full_pop", {63'd0, core_header_ack}, 64'd0);
      tick();
      l15_transducer_header_ack = 1'b0;
      #1;
      check_eq("t2_accept_c", {63'd0, core_header_ack}, 64'd1);
      tick();
      core_val = 1'b0;

      // 3: outstanding cap (A issued; issue B, C remains queued)
      l15_transducer_header_ack = 1'b1;
      #1;
      check_eq("t3_val_b", {63'd0, transducer_l15_val}, 64'd1);
      tick();
      check_eq("t3_cap", {63'd0, transducer_l15_val}, 64'd0);
      tick();
      check_eq("t3_cap_hold", {63'd0, transducer_l15_val}, 64'd0);
      l15_transducer_header_ack = 1'b0;

      // 4: interrupt return is acked and dropped
      set_rsp(64'h1111, 64'h2222, 4'd7);
      #1;
      check_eq("t4_req_ack", {63'd0, transducer_l15_req_ack}, 64'd1);
      tick();
      l15_transducer_val = 1'b0;
      #1;
      check_eq("t4_no_resp", {63'd0, core_resp_val}, 64'd0);
      check_eq("t4_out_unch", {63'd0, transducer_l15_val}, 64'd0);

      // 3 (cont.): one real response frees a slot
      set_rsp(64'hA5A5_0000_0000_00A0, 64'h5A5A_0000_0000_00A1, 4'd2);
      #1;
      check_eq("t3_rsp_ack", {63'd0, transducer_l15_req_ack}, 64'd1);
      tick();
      l15_transducer_val = 1'b0;
      #1;
      check_eq("t3_reassert", {63'd0, transducer_l15_val}, 64'd1);
      check_eq("t3_resp_val", {63'd0, core_resp_val}, 64'd1);

      // 5: response backpressure
      set_rsp(64'hB0B0_0000_0000_00B0, 64'h0B0B_0000_0000_00B1, 4'd3);
      #1;
      check_eq("t5_busy", {63'd0, transducer_l15_req_ack}, 64'd0);
      tick();
      check_eq("t5_busy2", {63'd0, transducer_l15_req_ack}, 64'd0);
      check_eq("t5_hold_d0", core_resp_data_0, 64'hA5A5_0000_0000_00A0);
      core_resp_ack = 1'b1;
      #1;
      check_eq("t5_ack_cycle", {63'd0, transducer_l15_req_ack}, 64'd0);
      tick();
      core_resp_ack = 1'b0;
      #1;
      check_eq("t5_emptied", {63'd0, core_resp_val}, 64'd0);
      check_eq("t5_free", {63'd0, transducer_l15_req_ack}, 64'd1);
      tick();
      l15_transducer_val = 1'b0;
      #1;
      check_eq("t5_resp_val", {63'd0, core_resp_val}, 64'd1);
      check_eq("t5_d0", core_resp_data_0, 64'hB0B0_0000_0000_00B0);
      check_eq("t5_d1", core_resp_data_1, 64'h0B0B_0000_0000_00B1);
      check_eq("t5_rt", {60'd0, core_resp_returntype}, 64'd3);
      core_resp_ack = 1'b1;
      tick();
      core_resp_ack = 1'b0;

      // 6: build FIFO=2, outstanding=1, response held, then reset mid-cycle
      l15_transducer_header_ack = 1'b1;
      set_req(5'd4, 3'd3, 32'h0000_4000, 64'hDDDD);
      #1;
      check_eq("t6_acc_d", {63'd0, core_header_ack}, 64'd1);
      tick();
      set_req(5'd5, 3'd3, 32'h0000_5000, 64'hEEEE);
      #1;
      check_eq("t6_val_d", {63'd0, transducer_l15_val}, 64'd1);
      tick();
      l15_transducer_header_ack = 1'b0;
      set_req(5'd6, 3'd3, 32'h0000_6000, 64'hFFFF);
      set_rsp(64'h6666, 64'h7777, 4'd1);
      #1;
      check_eq("t6_rsp_ack", {63'd0, transducer_l15_req_ack}, 64'd1);
      tick();
      l15_transducer_val = 1'b0;
      set_req(5'd7, 3'd0, 32'h0000_7000, 64'h1234);
      #1;
      check_eq("t6_held", {63'd0, core_resp_val}, 64'd1);
      check_eq("t6_issue", {63'd0, transducer_l15_val}, 64'd1);
      check_eq("t6_full", {63'd0, core_header_ack}, 64'd0);
      #1;
      nrst = 1'b1;
      req_q.delete();
      rsp_q.delete();
      l15_transducer_val = 1'b1;
      #1;
      check_eq("t6_rst_l15_val", {63'd0, transducer_l15_val}, 64'd0);
      check_eq("t6_rst_resp_val", {63'd0, core_resp_val}, 64'd0);
      check_eq("t6_rst_hdr_ack", {63'd0, core_header_ack}, 64'd0);
      check_eq("t6_rst_req_ack", {63'd0, transducer_l15_req_ack}, 64'd0);
      check_eq("t6_rst_addr", {24'd0, transducer_l15_address}, 64'd0);
      check_eq("t6_rst_d0", core_resp_data_0, 64'd0);
      tick();
      nrst = 1'b0;
      core_val = 1'b0;
      l15_transducer_val = 1'b0;
      #1;
      check_eq("t6_post_empty", {63'd0, transducer_l15_val}, 64'd0);
      check_eq("t6_post_resp", {63'd0, core_resp_val}, 64'd0);
      tick();
      set_req(5'd9, 3'd2, 32'h9000_0010, 64'h9999_8888_7777_6666);
      #1;
      check_eq("t6_new_ack", {63'd0, core_header_ack}, 64'd1);
      tick();
      core_val = 1'b0;
      #1;
      check_eq("t6_new_val", {63'd0, transducer_l15_val}, 64'd1);
      check_eq("t6_new_addr", {24'd0, transducer_l15_address}, 64'h00_9000_0010);
      l15_transducer_header_ack = 1'b1;
      tick();
      l15_transducer_header_ack = 1'b0;
      set_rsp(64'hCAFE, 64'hF00D, 4'd5);
      tick();
      l15_transducer_val = 1'b0;
      #1;
      check_eq("t6_new_resp", {63'd0, core_resp_val}, 64'd1);
      core_resp_ack = 1'b1;
      tick();
      core_resp_ack = 1'b0;
      tick();
      check_eq("sb_req_drain", 64'(req_q.size()), 64'd0);
      check_eq("sb_rsp_drain", 64'(rsp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/l15_transducer_bridge.md
Name: l15_transducer_bridge

Overview:
Sits directly downstream of the core's shared transducer port, between the core and the L1.5 cache.
- Decouples the two sides with a 2-entry request FIFO and a 1-entry response holding register.
- Caps the number of in-flight requests with an outstanding-request counter.
- Zero-extends core addresses to 40 bits.
- Acknowledges and drops interrupt-type returns instead of forwarding them to the core.

Parameters:
MAX_OUTSTANDING, 2, maximum requests header-acked by L1.5 but not yet answered (1..3)
INT_RET_TYPE, 4'd7, L1.5 returntype that is acked to L1.5 but never forwarded to the core
ADDR_W_CORE, 32, core-side address width

Ports:
clk  in  1  clock
nrst  in  1  reset; asynchronous, active-high (asserted = 1)
core_rqtype  in  5  core request type
core_size  in  3  core request size
core_address  in  ADDR_W_CORE  core request address
core_data  in  64  core store data
core_val  in  1  core request valid; held high until core_header_ack
core_header_ack  out  1  request accepted into FIFO (combinational)
core_resp_val  out  1  response available to core
core_resp_data_0  out  64  response data word 0
core_resp_data_1  out  64  response data word 1
core_resp_returntype  out  4  response type
core_resp_ack  in  1  core consumed the response
transducer_l15_rqtype  out  5  FIFO head rqtype
transducer_l15_size  out  3  FIFO head size
transducer_l15_address  out  40  FIFO head address, zero-extended
transducer_l15_data  out  64  FIFO head data
transducer_l15_val  out  1  request valid to L1.5
l15_transducer_header_ack  in  1  L1.5 accepted the head request
l15_transducer_val  in  1  L1.5 response valid
l15_transducer_data_0  in  64  response word 0
l15_transducer_data_1  in  64  response word 1
l15_transducer_returntype  in  4  response type
transducer_l15_req_ack  out  1  response captured (combinational)

Behaviour:
Reset (nrst=1, asynchronous):
- FIFO empty; head/tail pointers 0; outstanding counter 0; response register empty.
- All outputs 0 during reset.
- Reset mid-transaction discards all FIFO contents and any held response.

Request FIFO:
- 2 entries, each {rqtype, size, address, data}.
- core_header_ack = core_val & (fifo_count != 2). On acceptance the entry is pushed at the clock edge.
- There is no same-cycle bypass: a request is visible on the L1.5 side no earlier than 1 cycle after acceptance.
- When full, push is refused even if a pop occurs in the same cycle.
- Pointers are 1 bit and wrap; the count is 2 bits.

Request issue:
- transducer_l15_val = (fifo_count != 0) & (outstanding < MAX_OUTSTANDING).
- The L1.5-side payload fields are driven from the FIFO head and stay stable while val is high.
- Pop when transducer_l15_val & l15_transducer_header_ack.
- header_ack while val is low is ignored.

Outstanding counter:
- +1 on pop.
- −1 on a captured non-interrupt response.
- Both in the same cycle: unchanged.
- Saturates at 0: a decrement at 0 is ignored and flagged by a simulation-only assertion.

Response path:
- transducer_l15_req_ack = l15_transducer_val & response register empty.
- On req_ack with returntype == INT_RET_TYPE: acknowledge only. Do not capture, do not decrement.
- On req_ack with any other returntype: capture data_0, data_1 and returntype at the edge; core_resp_val rises the next cycle.
- core_resp_val and its fields are held until core_resp_ack. The register empties at that edge.
- No capture occurs in the cycle the register is being emptied; the next capture is possible one cycle later.
- core_resp_ack while core_resp_val is low is ignored.

Latency:
- Core accept to transducer_l15_val: 1 cycle.
- L1.5 response to core_resp_val: 1 cycle.

Test Plan:
1. Reset then a single load: core_address=32'h8000_0040, rqtype=0, core_val held -> core_header_ack same cycle; next cycle transducer_l15_val=1 with address 40'h00_8000_0040; header_ack pops; L1.5 returns data_0=64'hDEAD_BEEF_0000_0001, returntype=0 -> core_resp_val 1 cycle later with that data, held until core_resp_ack.
2. Back-to-back accepts with L1.5 stalled (header_ack=0): 2 accepts, third core_val held -> core_header_ack=0 until the first pop, then accepted.
3. MAX_OUTSTANDING=2: two pops with no responses -> transducer_l15_val=0 although the FIFO holds a third request; one response captured -> val reasserts next cycle.
4. Interrupt return: l15 val with returntype=7 -> transducer_l15_req_ack=1, core_resp_val stays 0, outstanding unchanged.
5. Response backpressure: response held with core_resp_ack=0 while a second l15_transducer_val arrives -> req_ack=0 until the cycle after core_resp_ack; the second response is then captured intact.
6. Asynchronous reset asserted mid-cycle with FIFO=2, outstanding=1, response held -> all outputs 0 immediately; after release the FIFO is empty and the first new request is issued normally.
